// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Active-low 7-segment codes {g,f,e,d,c,b,a} and BCD decoder.
// Revision: 1.0
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_counter_if.sv
`default_nettype none
// ============================================================================
// Module  : bcd_display_counter_if
// Brief   : Control, count and display signals of the BCD display counter.
// Revision: 1.0
// ============================================================================
interface bcd_display_counter_if #(
  parameter int N_DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  load;
  logic [4*N_DIGITS-1:0] load_val;
  logic [4*N_DIGITS-1:0] count_bcd;
  logic                  wrap;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   an;

  modport master (
    output en, up, clr, load, load_val,
    input  count_bcd, wrap, seg, an
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count_bcd, wrap, seg, an
  );
endinterface
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : tick_gen
// Brief   : Enable-gated prescaler; tick is high in the last cycle of each DIV.
// Revision: 1.0
// ============================================================================
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/bcd_display_counter.sv
`default_nettype none
// ============================================================================
// Module  : bcd_display_counter
// Brief   : N-digit BCD up/down counter with scanned 7-segment display output.
// Revision: 1.0
// ============================================================================
module bcd_display_counter
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int COUNT_DIV = 50_000_000,
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_LZ  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_display_counter_if.slave   bus
);
  localparam int                  W        = 4 * N_DIGITS;
  localparam int                  IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_RST   = N_DIGITS'(1);

  logic                w_count_tick;
  logic                w_scan_tick;
  logic [W-1:0]        r_count;
  logic [W-1:0]        w_count_next;
  logic [W-1:0]        w_load_sat;
  logic                w_all_nine;
  logic                w_all_zero;
  logic                r_wrap;
  logic [IDX_W-1:0]    r_scan_idx;
  logic [N_DIGITS-1:0] w_blank;
  logic [N_DIGITS-1:0] w_an_next;
  logic [6:0]          w_seg_next;
  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;

  tick_gen #(.DIV(COUNT_DIV)) u_count_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.clr | bus.load),
    .tick (w_count_tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .clr  (1'b0),
    .tick (w_scan_tick)
  );

  // Ripple a single +/-1 through the digits; carry starts set at digit 0.
  always_comb begin : next_count
    logic       carry;
    logic [3:0] d;
    logic [3:0] lv;
    carry        = 1'b1;
    d            = 4'd0;
    lv           = 4'd0;
    w_count_next = r_count;
    w_load_sat   = '0;
    w_all_nine   = 1'b1;
    w_all_zero   = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      d          = r_count[4*i +: 4];
      w_all_nine = w_all_nine && (d == 4'd9);
      w_all_zero = w_all_zero && (d == 4'd0);
      if (carry) begin
        if (bus.up) begin
          if (d == 4'd9) begin
            w_count_next[4*i +: 4] = 4'd0;
          end else begin
            w_count_next[4*i +: 4] = d + 4'd1;
            carry                  = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            w_count_next[4*i +: 4] = 4'd9;
          end else begin
            w_count_next[4*i +: 4] = d - 4'd1;
            carry                  = 1'b0;
          end
        end
      end
      lv                   = bus.load_val[4*i +: 4];
      w_load_sat[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_sat;
      r_wrap  <= 1'b0;
    end else if (w_count_tick) begin
      r_count <= w_count_next;
      r_wrap  <= bus.up ? w_all_nine : w_all_zero;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // Leading-zero detection scans from the top digit down; digit 0 stays lit.
  always_comb begin : display_next
    logic higher_zero;
    higher_zero = 1'b1;
    w_blank     = '0;
    w_an_next   = '0;
    w_seg_next  = SEG_BLANK;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (r_count[4*i +: 4] == 4'd0);
      w_blank[i]  = (BLANK_LZ != 0) && (i != 0) && higher_zero;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_scan_idx == IDX_W'(i)) begin
        w_an_next[i] = 1'b1;
        w_seg_next   = w_blank[i] ? SEG_BLANK : bcd_to_seg(r_count[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_idx <= '0;
      r_an       <= AN_RST;
      r_seg      <= SEG_0;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      if (w_scan_tick) begin
        r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
      end
    end
  end

  assign bus.count_bcd = r_count;
  assign bus.wrap      = r_wrap;
  assign bus.an        = r_an;
  assign bus.seg       = r_seg;
endmodule
`default_nettype wire
